// File: rtl/pc_update.sv
// pc_update -- program-counter stage of the single cycle processor.
//
// Registers the next instruction address each cycle from one of three
// sources: sequential (PC+4), branch target (PC+4 + offset*4) or jump
// target ({PC+4[top nibble], index, 00}). Advance is gated by instruction
// memory readiness and pipeline stall. A terminal HALT state freezes the
// PC until reset. A saturating 16-bit counter tallies taken transfers.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   PCsel         branch taken (Zero AND Branch)
//   Jump          unconditional jump in decode
//   BranchOffset  sign-extended word offset of the branch immediate
//   JumpTarget    26-bit jump index field
//   Halt          current instruction is halt
//   Stall         hold PC this cycle
//   imem_ready    instruction memory has presented the word at PC
//   PC            current instruction address (registered)
//   PCplus4       PC + 4, combinational from PC
//   fetch_valid   PC is a live fetch request (RUN state)
//   halted        block is in HALT
//   taken_count   saturating count of taken branches and jumps
module pc_update #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCsel,
    input  logic             Jump,
    input  logic [WIDTH-1:0] BranchOffset,
    input  logic [25:0]      JumpTarget,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCplus4,
    output logic             fetch_valid,
    output logic             halted,
    output logic [15:0]      taken_count
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    // Reset address with the byte-offset bits forced clear so PC[1:0]
    // stays 00 even if the parameter is misconfigured.
    localparam logic [WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[WIDTH-1:2], 2'b00};

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic             advance;
    logic             taken;
    logic             count_sat;

    // The shift by two drops the offset's top two bits; they carry no
    // information for a WIDTH-bit modulo add.
    logic unused_offset_top;
    assign unused_offset_top = ^BranchOffset[WIDTH-1:WIDTH-2];

    assign PCplus4       = PC + WIDTH'(4);
    assign branch_target = PCplus4 + {BranchOffset[WIDTH-3:0], 2'b00};
    assign jump_target   = {PCplus4[WIDTH-1:28], JumpTarget, 2'b00};

    assign advance   = (state == S_RUN) && imem_ready && !Stall;
    assign count_sat = (taken_count == 16'hFFFF);

    // Next-PC / next-state selection. Halt outranks Jump outranks PCsel;
    // when advance is low the decoder re-presents the same controls next
    // cycle, so nothing is consumed here.
    always_comb begin
        state_next = state;
        pc_next    = PC;
        taken      = 1'b0;
        case (state)
            S_BOOT: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                if (advance) begin
                    if (Halt) begin
                        state_next = S_HALT;
                    end else if (Jump) begin
                        pc_next = jump_target;
                        taken   = 1'b1;
                    end else if (PCsel) begin
                        pc_next = branch_target;
                        taken   = 1'b1;
                    end else begin
                        pc_next = PCplus4;
                    end
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                // Unreachable encoding: recover through BOOT.
                state_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_BOOT;
            PC          <= RESET_PC_ALIGNED;
            taken_count <= '0;
        end else begin
            state <= state_next;
            PC    <= pc_next;
            if (taken && !count_sat) begin
                taken_count <= taken_count + 16'd1;
            end
        end
    end

    // Both flags are pure state decodes, so they switch on the same edge
    // that moves the state register.
    assign fetch_valid = (state == S_RUN);
    assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_pc_update.sv
module tb_pc_update;

    localparam int          W     = 32;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCsel, Jump, Halt, Stall, imem_ready;
    logic [31:0] BranchOffset;
    logic [25:0] JumpTarget;
    logic [31:0] PC, PCplus4;
    logic        fetch_valid, halted;
    logic [15:0] taken_count;

    pc_update #(.WIDTH(W), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .PCsel(PCsel), .Jump(Jump),
        .BranchOffset(BranchOffset), .JumpTarget(JumpTarget),
        .Halt(Halt), .Stall(Stall), .imem_ready(imem_ready),
        .PC(PC), .PCplus4(PCplus4), .fetch_valid(fetch_valid),
        .halted(halted), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic        fv;
        logic        hl;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Reference model: mode 0 = booting, 1 = running, 2 = halted.
    int          m_mode = 0;
    logic [31:0] m_pc   = RPC;
    int          m_cnt  = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled 1 time unit after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("pc",          PC,                  e.pc);
                chk("pcplus4",     PCplus4,             e.pcp4);
                chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
                chk("halted",      {31'd0, halted},      {31'd0, e.hl});
                chk("taken_count", {16'd0, taken_count}, {16'd0, e.cnt});
            end
        end
    end

    // Drive one cycle of inputs (at negedge) and push the model's view of
    // the state after the following rising edge.
    task automatic cyc(bit r, bit ps, bit j, bit h, bit st, bit rdy,
                       logic [31:0] off, logic [25:0] jt);
        exp_t        e;
        logic [31:0] p4;
        @(negedge clk);
        rst = r; PCsel = ps; Jump = j; Halt = h; Stall = st; imem_ready = rdy;
        BranchOffset = off; JumpTarget = jt;
        p4 = m_pc + 32'd4;
        if (r) begin
            m_mode = 0; m_pc = RPC; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && rdy && !st) begin
            if (h) begin
                m_mode = 2;
            end else if (j) begin
                m_pc = (p4 & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
                if (m_cnt < 65535) m_cnt++;
            end else if (ps) begin
                m_pc = p4 + off * 32'd4;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_pc = p4;
            end
        end
        e.pc   = m_pc;
        e.pcp4 = m_pc + 32'd4;
        e.fv   = (m_mode == 1);
        e.hl   = (m_mode == 2);
        e.cnt  = 16'(m_cnt);
        q.push_back(e);
    endtask

    task automatic seq_step();
        cyc(0, 0, 0, 0, 0, 1, 32'h0, 26'h0);
    endtask

    task automatic branch(logic [31:0] off);
        cyc(0, 1, 0, 0, 0, 1, off, 26'h0);
    endtask

    // Steer the PC to an arbitrary word address with one taken branch.
    task automatic goto_pc(logic [31:0] target);
        logic [31:0] off;
        off = (target - (m_pc + 32'd4)) >> 2;
        branch(off);
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 1, 32'h0, 26'h0);
    endtask

    initial begin
        rst = 1; PCsel = 0; Jump = 0; Halt = 0; Stall = 0; imem_ready = 1;
        BranchOffset = '0; JumpTarget = '0;

        // Reset and boot, then three sequential fetches.
        do_reset(2);
        cyc(0, 1, 1, 1, 0, 1, 32'h5, 26'h7);   // BOOT ignores controls
        seq_step(); seq_step(); seq_step();

        // Branch backwards and forwards from 0x200.
        goto_pc(32'h200);
        branch(32'hFFFF_FFFE);                 // -> 0x1FC
        goto_pc(32'h200);
        branch(32'h0000_0003);                 // -> 0x210
        branch(32'hC000_0001);                 // top offset bits discarded

        // Jump outranks branch.
        goto_pc(32'h3000_0040);
        cyc(0, 1, 1, 0, 0, 1, 32'h0000_0100, 26'h0000010);

        // Stall two cycles, imem not ready one cycle, then take branch.
        goto_pc(32'h40);
        cyc(0, 1, 0, 0, 1, 1, 32'h10, 26'h0);
        cyc(0, 1, 0, 0, 1, 1, 32'h10, 26'h0);
        cyc(0, 1, 0, 0, 0, 0, 32'h10, 26'h0);
        cyc(0, 1, 0, 0, 0, 1, 32'h10, 26'h0);

        // Random traffic; halt is rare and reset occasionally recovers.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                $urandom, 26'($urandom));
        end

        // Saturation: 65,537 consecutive taken branches after a fresh boot.
        do_reset(1);
        seq_step();
        for (int i = 0; i < 65537; i++) branch($urandom);
        cyc(0, 0, 1, 0, 0, 1, 32'h0, 26'h3FF_FFFF);

        // Wrap, halt with jump, reset out of halt.
        goto_pc(32'hFFFF_FFFC);
        seq_step();                            // -> 0x0
        cyc(0, 1, 1, 1, 0, 1, 32'h4, 26'h123);
        cyc(0, 1, 1, 0, 0, 1, 32'h4, 26'h123);
        seq_step();
        cyc(1, 0, 0, 0, 0, 1, 32'h0, 26'h0);
        seq_step(); seq_step();

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        if (checks < 12) begin
            errors++;
            $display("FAIL check_count: got %0d expected >= 12", checks);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
